// File: rtl/mpu_write_port.sv
// MPU register-write port: decodes pixel writes, auto-advances a coordinate
// cursor and queues {y, x, data} entries in a first-word-fall-through FIFO.
module mpu_write_port #(
    parameter int X_WIDTH       = 9,
    parameter int Y_WIDTH       = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 240,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   chipSelect,
    input  logic                                   writeEnable,
    input  logic [2:0]                             registerSelect,
    input  logic [7:0]                             registerData,
    output logic [7:0]                             registerReadData,
    output logic [Y_WIDTH+X_WIDTH+DATA_WIDTH-1:0]  pendingWriteBus,
    output logic                                   pendingWriteValid,
    input  logic                                   pendingWriteReady,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]        fifoLevel,
    output logic                                   overflow
);
    localparam int ENTRY_W = Y_WIDTH + X_WIDTH + DATA_WIDTH;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);

    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(SCREEN_HEIGHT - 1);

    localparam logic [2:0] REG_DATA    = 3'd0;
    localparam logic [2:0] REG_X_LOW   = 3'd1;
    localparam logic [2:0] REG_X_HIGH  = 3'd2;
    localparam logic [2:0] REG_Y_LOW   = 3'd3;
    localparam logic [2:0] REG_Y_HIGH  = 3'd4;
    localparam logic [2:0] REG_CONTROL = 3'd5;
    localparam logic [2:0] REG_STATUS  = 3'd6;
    localparam logic [2:0] REG_LEVEL   = 3'd7;

    localparam logic [1:0] MODE_HOLD   = 2'd0;
    localparam logic [1:0] MODE_RASTER = 2'd1;
    localparam logic [1:0] MODE_COLUMN = 2'd2;

    logic [X_WIDTH-1:0] cursorX, nextX, xInc;
    logic [Y_WIDTH-1:0] cursorY, nextY, yInc;
    logic [15:0]        xPad, yPad;
    logic [1:0]         mode;
    logic               strobePrev, strobe;
    logic               dataWrite, push, pop, full, empty;
    logic [PTR_W-1:0]   wrPtr, rdPtr;
    logic [ENTRY_W-1:0] fifoMem [FIFO_DEPTH];

    assign xPad = 16'(cursorX);
    assign yPad = 16'(cursorY);

    assign strobe    = chipSelect && writeEnable && !strobePrev;
    assign empty     = (fifoLevel == '0);
    assign full      = (fifoLevel == LVL_W'(FIFO_DEPTH));
    assign pop       = !empty && pendingWriteReady;
    assign dataWrite = strobe && (registerSelect == REG_DATA);
    assign push      = dataWrite && (!full || pop);

    assign pendingWriteValid = !empty;
    assign pendingWriteBus   = empty ? '0 : fifoMem[rdPtr];

    always_comb begin
        xInc  = (cursorX >= X_LAST) ? '0 : cursorX + X_WIDTH'(1);
        yInc  = (cursorY >= Y_LAST) ? '0 : cursorY + Y_WIDTH'(1);
        nextX = cursorX;
        nextY = cursorY;
        case (mode)
            MODE_RASTER: begin
                nextX = xInc;
                if (cursorX >= X_LAST) nextY = yInc;
            end
            MODE_COLUMN: begin
                nextY = yInc;
                if (cursorY >= Y_LAST) nextX = xInc;
            end
            default: ;
        endcase
    end

    always_comb begin
        registerReadData = '0;
        case (registerSelect)
            REG_X_LOW:   registerReadData = xPad[7:0];
            REG_X_HIGH:  registerReadData = xPad[15:8];
            REG_Y_LOW:   registerReadData = yPad[7:0];
            REG_Y_HIGH:  registerReadData = yPad[15:8];
            REG_CONTROL: registerReadData = {6'b0, mode};
            REG_STATUS:  registerReadData = {5'b0, overflow, full, empty};
            REG_LEVEL:   registerReadData = 8'(fifoLevel);
            default:     registerReadData = '0;
        endcase
    end

    // History resets high so an access held across reset release is not taken as a new write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            strobePrev <= 1'b1;
            cursorX    <= '0;
            cursorY    <= '0;
            mode       <= MODE_RASTER;
            overflow   <= 1'b0;
        end else begin
            strobePrev <= chipSelect && writeEnable;
            if (strobe) begin
                case (registerSelect)
                    REG_DATA: begin
                        if (push) begin
                            cursorX <= nextX;
                            cursorY <= nextY;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    REG_X_LOW:  cursorX <= X_WIDTH'({xPad[15:8], registerData});
                    REG_X_HIGH: cursorX <= X_WIDTH'({registerData, xPad[7:0]});
                    REG_Y_LOW:  cursorY <= Y_WIDTH'({yPad[15:8], registerData});
                    REG_Y_HIGH: cursorY <= Y_WIDTH'({registerData, yPad[7:0]});
                    REG_CONTROL: begin
                        mode <= registerData[1:0];
                        if (registerData[7]) overflow <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoLevel <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifoLevel <= fifoLevel + LVL_W'(1);
                2'b01:   fifoLevel <= fifoLevel - LVL_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifoMem[wrPtr] <= {cursorY, cursorX, registerData[DATA_WIDTH-1:0]};
    end

endmodule

// File: tb/tb_mpu_write_port.sv
// Directed bench for mpu_write_port: cursor wrap modes, FIFO ordering,
// overflow handling, strobe edge detection and reset behaviour.
module tb_mpu_write_port;
    logic        clock = 1'b0;
    logic        reset;
    logic        chipSelect, writeEnable, pendingWriteReady;
    logic [2:0]  registerSelect;
    logic [7:0]  registerData, registerReadData;
    logic [24:0] pendingWriteBus;
    logic        pendingWriteValid, overflow;
    logic [4:0]  fifoLevel;

    int checks = 0;
    int fails  = 0;

    mpu_write_port #(
        .X_WIDTH(9), .Y_WIDTH(8), .DATA_WIDTH(8),
        .SCREEN_WIDTH(320), .SCREEN_HEIGHT(240), .FIFO_DEPTH(16)
    ) dut (
        .clock(clock), .reset(reset),
        .chipSelect(chipSelect), .writeEnable(writeEnable),
        .registerSelect(registerSelect), .registerData(registerData),
        .registerReadData(registerReadData),
        .pendingWriteBus(pendingWriteBus), .pendingWriteValid(pendingWriteValid),
        .pendingWriteReady(pendingWriteReady),
        .fifoLevel(fifoLevel), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // One-cycle access starting at a falling edge; returns at the next falling edge.
    task automatic mpuWrite(input logic [2:0] sel, input logic [7:0] data);
        @(negedge clock);
        chipSelect = 1'b1; writeEnable = 1'b1;
        registerSelect = sel; registerData = data;
        @(negedge clock);
        chipSelect = 1'b0; writeEnable = 1'b0;
    endtask

    task automatic readReg(input logic [2:0] sel, output logic [7:0] val);
        registerSelect = sel;
        #1;
        val = registerReadData;
    endtask

    task automatic test_reset;
        logic [7:0] r;
        reset = 1'b1; chipSelect = 0; writeEnable = 0; pendingWriteReady = 0;
        registerSelect = 0; registerData = 0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (fifoLevel !== 5'd0) begin fails++; $display("FAIL reset_level: got %0d expected 0", fifoLevel); end
        checks++; if (pendingWriteValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", pendingWriteValid); end
        checks++; if (pendingWriteBus !== 25'd0) begin fails++; $display("FAIL reset_bus: got %h expected 0", pendingWriteBus); end
        readReg(3'd1, r);
        checks++; if (r !== 8'h00) begin fails++; $display("FAIL reset_xlow: got %h expected 00", r); end
        readReg(3'd5, r);
        checks++; if (r !== 8'h01) begin fails++; $display("FAIL reset_mode: got %h expected 01", r); end
        readReg(3'd6, r);
        checks++; if (r !== 8'h01) begin fails++; $display("FAIL reset_status: got %h expected 01", r); end
    endtask

    task automatic test_raster_wrap;
        logic [7:0] r;
        mpuWrite(3'd1, 8'h3F);
        mpuWrite(3'd2, 8'h01);
        mpuWrite(3'd3, 8'hEF);
        readReg(3'd2, r);
        checks++; if (r !== 8'h01) begin fails++; $display("FAIL raster_xhigh_read: got %h expected 01", r); end
        pendingWriteReady = 1'b1;
        mpuWrite(3'd0, 8'h5A);
        checks++; if (pendingWriteValid !== 1'b1) begin fails++; $display("FAIL raster_valid: got %b expected 1", pendingWriteValid); end
        checks++; if (pendingWriteBus !== {8'd239, 9'd319, 8'h5A}) begin fails++; $display("FAIL raster_entry: got %h expected %h", pendingWriteBus, {8'd239, 9'd319, 8'h5A}); end
        @(negedge clock);
        checks++; if (pendingWriteValid !== 1'b0) begin fails++; $display("FAIL raster_popped: got %b expected 0", pendingWriteValid); end
        pendingWriteReady = 1'b0;
        readReg(3'd1, r);
        checks++; if (r !== 8'h00) begin fails++; $display("FAIL raster_wrap_xlow: got %h expected 00", r); end
        readReg(3'd2, r);
        checks++; if (r !== 8'h00) begin fails++; $display("FAIL raster_wrap_xhigh: got %h expected 00", r); end
        readReg(3'd3, r);
        checks++; if (r !== 8'h00) begin fails++; $display("FAIL raster_wrap_y: got %h expected 00", r); end
    endtask

    task automatic test_column;
        logic [7:0]  r;
        logic [24:0] exp [3];
        exp[0] = {8'd238, 9'd5, 8'd1};
        exp[1] = {8'd239, 9'd5, 8'd2};
        exp[2] = {8'd0,   9'd6, 8'd3};
        mpuWrite(3'd5, 8'h02);
        mpuWrite(3'd1, 8'h05);
        mpuWrite(3'd2, 8'h00);
        mpuWrite(3'd3, 8'hEE);
        mpuWrite(3'd0, 8'h01);
        mpuWrite(3'd0, 8'h02);
        mpuWrite(3'd0, 8'h03);
        checks++; if (fifoLevel !== 5'd3) begin fails++; $display("FAIL column_level: got %0d expected 3", fifoLevel); end
        readReg(3'd6, r);
        checks++; if (r !== 8'h00) begin fails++; $display("FAIL column_status: got %h expected 00", r); end
        readReg(3'd7, r);
        checks++; if (r !== 8'h03) begin fails++; $display("FAIL column_level_reg: got %h expected 03", r); end
        pendingWriteReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (pendingWriteBus !== exp[i]) begin fails++; $display("FAIL column_entry%0d: got %h expected %h", i, pendingWriteBus, exp[i]); end
            @(negedge clock);
        end
        pendingWriteReady = 1'b0;
        checks++; if (fifoLevel !== 5'd0) begin fails++; $display("FAIL column_drained: got %0d expected 0", fifoLevel); end
        readReg(3'd1, r);
        checks++; if (r !== 8'h06) begin fails++; $display("FAIL column_cursor_x: got %h expected 06", r); end
        readReg(3'd3, r);
        checks++; if (r !== 8'h01) begin fails++; $display("FAIL column_cursor_y: got %h expected 01", r); end
    endtask

    task automatic test_overflow;
        logic [7:0] r;
        mpuWrite(3'd5, 8'h00);
        mpuWrite(3'd1, 8'h10);
        mpuWrite(3'd3, 8'h20);
        for (int i = 1; i <= 16; i++) mpuWrite(3'd0, 8'(i));
        checks++; if (fifoLevel !== 5'd16) begin fails++; $display("FAIL ovf_level_full: got %0d expected 16", fifoLevel); end
        readReg(3'd6, r);
        checks++; if (r !== 8'h02) begin fails++; $display("FAIL ovf_status_full: got %h expected 02", r); end
        // RASTER for the dropped write, so a wrongful advance would be visible
        mpuWrite(3'd5, 8'h01);
        mpuWrite(3'd0, 8'h11);
        checks++; if (fifoLevel !== 5'd16) begin fails++; $display("FAIL ovf_level_after_drop: got %0d expected 16", fifoLevel); end
        readReg(3'd6, r);
        checks++; if (r !== 8'h06) begin fails++; $display("FAIL ovf_status: got %h expected 06", r); end
        readReg(3'd1, r);
        checks++; if (r !== 8'h10) begin fails++; $display("FAIL ovf_cursor_x: got %h expected 10", r); end
        readReg(3'd3, r);
        checks++; if (r !== 8'h20) begin fails++; $display("FAIL ovf_cursor_y: got %h expected 20", r); end
        checks++; if (pendingWriteBus !== {8'h20, 9'h010, 8'd1}) begin fails++; $display("FAIL ovf_head: got %h expected %h", pendingWriteBus, {8'h20, 9'h010, 8'd1}); end
        mpuWrite(3'd5, 8'h80);
        readReg(3'd6, r);
        checks++; if (r !== 8'h02) begin fails++; $display("FAIL ovf_cleared: got %h expected 02", r); end
        readReg(3'd5, r);
        checks++; if (r !== 8'h00) begin fails++; $display("FAIL ovf_mode_hold: got %h expected 00", r); end
    endtask

    task automatic test_full_push_pop;
        logic [7:0] r;
        logic [7:0] d;
        @(negedge clock);
        chipSelect = 1'b1; writeEnable = 1'b1; registerSelect = 3'd0;
        registerData = 8'hAA; pendingWriteReady = 1'b1;
        @(negedge clock);
        chipSelect = 1'b0; writeEnable = 1'b0; pendingWriteReady = 1'b0;
        checks++; if (fifoLevel !== 5'd16) begin fails++; $display("FAIL fpp_level: got %0d expected 16", fifoLevel); end
        readReg(3'd6, r);
        checks++; if (r !== 8'h02) begin fails++; $display("FAIL fpp_status: got %h expected 02", r); end
        pendingWriteReady = 1'b1;
        for (int k = 0; k < 16; k++) begin
            d = (k < 15) ? 8'(k + 2) : 8'hAA;
            checks++; if (pendingWriteBus !== {8'h20, 9'h010, d}) begin fails++; $display("FAIL fpp_order%0d: got %h expected %h", k, pendingWriteBus, {8'h20, 9'h010, d}); end
            @(negedge clock);
        end
        pendingWriteReady = 1'b0;
        checks++; if (pendingWriteValid !== 1'b0) begin fails++; $display("FAIL fpp_drained: got %b expected 0", pendingWriteValid); end
    endtask

    task automatic test_long_access;
        @(negedge clock);
        chipSelect = 1'b1; writeEnable = 1'b1; registerSelect = 3'd0; registerData = 8'h77;
        repeat (5) @(negedge clock);
        chipSelect = 1'b0; writeEnable = 1'b0;
        checks++; if (fifoLevel !== 5'd1) begin fails++; $display("FAIL long_level: got %0d expected 1", fifoLevel); end
        checks++; if (pendingWriteBus !== {8'h20, 9'h010, 8'h77}) begin fails++; $display("FAIL long_entry: got %h expected %h", pendingWriteBus, {8'h20, 9'h010, 8'h77}); end
        pendingWriteReady = 1'b1;
        @(negedge clock);
        pendingWriteReady = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [7:0] r;
        for (int i = 0; i < 4; i++) mpuWrite(3'd0, 8'(8'h41 + i));
        checks++; if (fifoLevel !== 5'd4) begin fails++; $display("FAIL rmid_level_before: got %0d expected 4", fifoLevel); end
        @(negedge clock);
        chipSelect = 1'b1; writeEnable = 1'b1; registerSelect = 3'd0; registerData = 8'h99;
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        checks++; if (pendingWriteValid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b expected 0", pendingWriteValid); end
        checks++; if (fifoLevel !== 5'd0) begin fails++; $display("FAIL rmid_level: got %0d expected 0", fifoLevel); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (fifoLevel !== 5'd0) begin fails++; $display("FAIL rmid_no_strobe_level: got %0d expected 0", fifoLevel); end
        checks++; if (pendingWriteValid !== 1'b0) begin fails++; $display("FAIL rmid_no_strobe_valid: got %b expected 0", pendingWriteValid); end
        chipSelect = 1'b0; writeEnable = 1'b0;
        readReg(3'd1, r);
        checks++; if (r !== 8'h00) begin fails++; $display("FAIL rmid_x: got %h expected 00", r); end
        readReg(3'd3, r);
        checks++; if (r !== 8'h00) begin fails++; $display("FAIL rmid_y: got %h expected 00", r); end
        readReg(3'd5, r);
        checks++; if (r !== 8'h01) begin fails++; $display("FAIL rmid_mode: got %h expected 01", r); end
    endtask

    initial begin
        test_reset();
        test_raster_wrap();
        test_column();
        test_overflow();
        test_full_push_pop();
        test_long_access();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
